// File: rtl/crank_wheel_pkg.sv
// Shared types and helpers for the crank/cam trigger-wheel generator.
`timescale 1ns/1ps
package crank_wheel_pkg;

  // Ramp behaviour selected per revolution; the raw code 3 decodes to constant.
  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_ACCEL = 2'd1,
    MODE_DECEL = 2'd2
  } mode_e;

  // Top-level sequencer states, kept as plain constants for legacy tools.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic mode_e mode_decode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_ACCEL;
      2'd2:    return MODE_DECEL;
      default: return MODE_CONST;
    endcase
  endfunction

endpackage

// File: rtl/crank_period_ramp.sv
// Saturating per-tooth update of the prescaler period.
`timescale 1ns/1ps
module crank_period_ramp
  import crank_wheel_pkg::*;
#(
  parameter int unsigned PW = 16
) (
  input  logic [1:0]    mode_i,
  input  logic [PW-1:0] period_i,
  input  logic [PW-1:0] period_min_i,
  input  logic [PW-1:0] period_max_i,
  input  logic [PW-1:0] ramp_step_i,
  output logic [PW-1:0] period_o
);

  // One extra bit catches borrow/carry so the result never wraps.
  logic [PW:0] diff;
  logic [PW:0] sum;

  // Select the clamped next period for the decoded ramp mode.
  always_comb begin
    diff = {1'b0, period_i} - {1'b0, ramp_step_i};
    sum  = {1'b0, period_i} + {1'b0, ramp_step_i};
    unique case (mode_decode(mode_i))
      MODE_ACCEL: period_o = (diff[PW] || (diff[PW-1:0] < period_min_i)) ? period_min_i
                                                                          : diff[PW-1:0];
      MODE_DECEL: period_o = (sum[PW] || (sum[PW-1:0] > period_max_i)) ? period_max_i
                                                                        : sum[PW-1:0];
      default:    period_o = period_i;
    endcase
  end

endmodule

// File: rtl/crank_wheel_gen.sv
// N-minus-M crank wheel and cam window generator with per-tooth period ramp.
`timescale 1ns/1ps
module crank_wheel_gen
  import crank_wheel_pkg::*;
#(
  parameter int unsigned TOOTH_NUM       = 60,
  parameter int unsigned GAP_TEETH       = 2,
  parameter int unsigned TICKS_PER_TOOTH = 64,
  parameter int unsigned PW              = 16,
  parameter int unsigned CAM_CH          = 1,
  parameter int unsigned START_TOOTH     = 0,
  localparam int unsigned TP             = TOOTH_NUM - GAP_TEETH,
  localparam int unsigned TW             = $clog2(TP)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [PW-1:0]        period_init,
  input  logic [PW-1:0]        period_min,
  input  logic [PW-1:0]        period_max,
  input  logic [PW-1:0]        ramp_step,
  input  logic [CAM_CH*TW-1:0] cam_start,
  input  logic [CAM_CH*TW-1:0] cam_end,
  output logic                 vr_out,
  output logic [CAM_CH-1:0]    cam_out,
  output logic [TW-1:0]        tooth_idx,
  output logic                 rev_pulse,
  output logic                 cam_phase,
  output logic [PW-1:0]        cur_period
);

  localparam int unsigned LONG_L = TICKS_PER_TOOTH * (GAP_TEETH + 1);
  localparam int unsigned TCW    = $clog2(LONG_L);

  localparam logic [TCW-1:0] N_LAST     = TCW'(TICKS_PER_TOOTH - 1);
  localparam logic [TCW-1:0] L_LAST     = TCW'(LONG_L - 1);
  localparam logic [TCW-1:0] N_HALF     = TCW'(TICKS_PER_TOOTH / 2);
  localparam logic [TCW-1:0] L_HALF     = TCW'(LONG_L / 2);
  localparam logic [TW-1:0]  LAST_TOOTH = TW'(TP - 1);
  localparam logic [TW-1:0]  FIRST_TOTH = TW'(START_TOOTH);

  // Shadow copy of the run configuration; declared here because its field
  // widths follow this module's parameters.
  typedef struct packed {
    logic [1:0]           mode;
    logic [PW-1:0]        period_min;
    logic [PW-1:0]        period_max;
    logic [PW-1:0]        ramp_step;
    logic [CAM_CH*TW-1:0] cam_start;
    logic [CAM_CH*TW-1:0] cam_end;
  } shadow_t;

  logic [0:0]        state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [TCW-1:0]    tick_q, tick_d;
  logic [TW-1:0]     tooth_q, tooth_d;
  logic              phase_q, phase_d;
  logic [PW-1:0]     period_q, period_d;
  logic              vr_q, vr_d;
  logic [CAM_CH-1:0] cam_q, cam_d;
  logic              rev_q, rev_d;
  shadow_t           cfg_q, cfg_d;

  shadow_t           cfg_in;
  logic              tick_fire;
  logic              long_tooth;
  logic              tooth_end;
  logic [PW-1:0]     period_ramped;
  logic [CAM_CH-1:0] cam_hit;

  assign cfg_in = '{mode:       mode,
                    period_min: period_min,
                    period_max: period_max,
                    ramp_step:  ramp_step,
                    cam_start:  cam_start,
                    cam_end:    cam_end};

  assign tick_fire  = (presc_q == period_q);
  assign long_tooth = (tooth_q == LAST_TOOTH);
  assign tooth_end  = tick_fire && (tick_q == (long_tooth ? L_LAST : N_LAST));

  // Ramp always sees the shadow of the revolution now ending.
  crank_period_ramp #(
    .PW(PW)
  ) u_ramp (
    .mode_i       (cfg_q.mode),
    .period_i     (period_q),
    .period_min_i (cfg_q.period_min),
    .period_max_i (cfg_q.period_max),
    .ramp_step_i  (cfg_q.ramp_step),
    .period_o     (period_ramped)
  );

  // Cam windows compare the registered tooth index against shadow bounds.
  always_comb begin
    cam_hit = '0;
    for (int i = 0; i < int'(CAM_CH); i++) begin
      cam_hit[i] = phase_q && (cfg_q.cam_start[i*TW +: TW] <= tooth_q)
                           && (tooth_q < cfg_q.cam_end[i*TW +: TW]);
    end
  end

  // Sequencer, prescaler, tick/tooth counters and output next-state.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    tick_d   = tick_q;
    tooth_d  = tooth_q;
    phase_d  = phase_q;
    period_d = period_q;
    cfg_d    = cfg_q;
    vr_d     = 1'b0;
    cam_d    = '0;
    rev_d    = 1'b0;

    if (state_q == ST_IDLE) begin
      if (en) begin
        state_d  = ST_RUN;
        presc_d  = '0;
        tick_d   = '0;
        tooth_d  = FIRST_TOTH;
        period_d = period_init;
        cfg_d    = cfg_in;
      end
    end else if (!en) begin
      state_d  = ST_IDLE;
      presc_d  = '0;
      tick_d   = '0;
      tooth_d  = '0;
      phase_d  = 1'b0;
      period_d = '0;
    end else begin
      presc_d = tick_fire ? '0 : presc_q + 1'b1;
      if (tooth_end) begin
        tick_d   = '0;
        period_d = period_ramped;
        if (long_tooth) begin
          tooth_d = '0;
          phase_d = ~phase_q;
          rev_d   = 1'b1;
          cfg_d   = cfg_in;
        end else begin
          tooth_d = tooth_q + 1'b1;
        end
      end else if (tick_fire) begin
        tick_d = tick_q + 1'b1;
      end
      // High for the second half of whichever tooth the counters move into.
      vr_d  = (tick_d >= ((tooth_d == LAST_TOOTH) ? L_HALF : N_HALF));
      cam_d = cam_hit;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      tick_q   <= '0;
      tooth_q  <= '0;
      phase_q  <= 1'b0;
      period_q <= '0;
      vr_q     <= 1'b0;
      cam_q    <= '0;
      rev_q    <= 1'b0;
      cfg_q    <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      tooth_q  <= tooth_d;
      phase_q  <= phase_d;
      period_q <= period_d;
      vr_q     <= vr_d;
      cam_q    <= cam_d;
      rev_q    <= rev_d;
      cfg_q    <= cfg_d;
    end
  end

  assign vr_out     = vr_q;
  assign cam_out    = cam_q;
  assign tooth_idx  = tooth_q;
  assign rev_pulse  = rev_q;
  assign cam_phase  = phase_q;
  assign cur_period = period_q;

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Self-checking bench for crank_wheel_gen with default wheel geometry (60-2).
`timescale 1ns/1ps
module tb_crank_wheel_gen;

  localparam int unsigned PW   = 16;
  localparam int unsigned TP   = 58;
  localparam int unsigned TW   = $clog2(TP);
  localparam int          REV4 = 15360;  // clks per revolution at period 3

  logic          clk = 1'b0;
  logic          rst, en;
  logic [1:0]    mode;
  logic [PW-1:0] period_init, period_min, period_max, ramp_step;
  logic [TW-1:0] cam_start, cam_end;
  logic          vr_out, rev_pulse, cam_phase;
  logic [0:0]    cam_out;
  logic [TW-1:0] tooth_idx;
  logic [PW-1:0] cur_period;

  logic [1:0]    rt_mode;
  logic [PW-1:0] rt_cur, rt_min, rt_max, rt_step, rt_out;

  always #5 clk = ~clk;

  crank_wheel_gen #(
    .TOOTH_NUM       (60),
    .GAP_TEETH       (2),
    .TICKS_PER_TOOTH (64),
    .PW              (PW),
    .CAM_CH          (1),
    .START_TOOTH     (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .period_init (period_init),
    .period_min  (period_min),
    .period_max  (period_max),
    .ramp_step   (ramp_step),
    .cam_start   (cam_start),
    .cam_end     (cam_end),
    .vr_out      (vr_out),
    .cam_out     (cam_out),
    .tooth_idx   (tooth_idx),
    .rev_pulse   (rev_pulse),
    .cam_phase   (cam_phase),
    .cur_period  (cur_period)
  );

  crank_period_ramp #(
    .PW(PW)
  ) u_ramp_chk (
    .mode_i       (rt_mode),
    .period_i     (rt_cur),
    .period_min_i (rt_min),
    .period_max_i (rt_max),
    .ramp_step_i  (rt_step),
    .period_o     (rt_out)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int c0       = 0;
  int rise_q[$];
  int rev_q[$];
  bit mon_on   = 1'b0;
  bit mon_geom = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc - c0);
    end
  endtask

  // Geometry of the period-3 constant run, as a function of clks since start.
  function automatic int tooth_at(input int n);
    int pos;
    pos = n % REV4;
    return (pos < 57 * 256) ? pos / 256 : 57;
  endfunction

  function automatic int phase_at(input int n);
    return (n / REV4) % 2;
  endfunction

  function automatic int cam_at(input int n);
    return (phase_at(n) == 1 && tooth_at(n) >= 4 && tooth_at(n) < 54) ? 1 : 0;
  endfunction

  // Scoreboard side: pop expected vr rises and rev pulses as the DUT produces them.
  initial begin
    logic vr_prev;
    int   n;
    int   rises_since_rev;
    vr_prev = 1'b0;
    rises_since_rev = 0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        n = cyc - c0;
        if (vr_out === 1'b1 && vr_prev === 1'b0) begin
          rises_since_rev++;
          if (rise_q.size() == 0) check("vr_rise_extra", n, 32'hFFFF_FFFF);
          else check("vr_rise_cycle", n, rise_q.pop_front());
        end
        if (rev_pulse === 1'b1) begin
          if (rev_q.size() == 0) check("rev_pulse_extra", n, 32'hFFFF_FFFF);
          else check("rev_pulse_cycle", n, rev_q.pop_front());
          check("rises_per_rev", rises_since_rev, TP);
          rises_since_rev = 0;
        end
        if (mon_geom && n >= 1 && failures < 40) begin
          check("tooth_idx_track", tooth_idx, tooth_at(n));
          check("cam_phase_track", cam_phase, phase_at(n));
          check("cam_out_track", cam_out, cam_at(n - 1));
          check("rev_pulse_level", rev_pulse, (n % REV4 == 0) ? 1 : 0);
        end
      end else begin
        rises_since_rev = 0;
      end
      vr_prev = vr_out;
    end
  end

  task automatic start_run(input logic [1:0] m, input logic [PW-1:0] pi, input logic [PW-1:0] pmn,
                           input logic [PW-1:0] pmx, input logic [PW-1:0] st,
                           input logic [TW-1:0] cs, input logic [TW-1:0] ce);
    mode = m; period_init = pi; period_min = pmn; period_max = pmx; ramp_step = st;
    cam_start = cs; cam_end = ce; en = 1'b1;
    @(posedge clk); #2;
    c0 = cyc;
  endtask

  task automatic stop_run();
    en = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic wait_until(input int n);
    while (cyc - c0 < n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vr_out"}, vr_out, 0);
    check({tag, "_cam_out"}, cam_out, 0);
    check({tag, "_tooth_idx"}, tooth_idx, 0);
    check({tag, "_rev_pulse"}, rev_pulse, 0);
    check({tag, "_cam_phase"}, cam_phase, 0);
    check({tag, "_cur_period"}, cur_period, 0);
  endtask

  typedef struct {
    logic [1:0]    mode;
    logic [PW-1:0] cur, pmin, pmax, step, exp;
  } ramp_vec_t;

  ramp_vec_t rv[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'd0;
    period_init = '0; period_min = '0; period_max = '0; ramp_step = '0;
    cam_start = '0; cam_end = '0;

    // Period update vectors: mode, cur, min, max, step, expected.
    rv[0]  = '{2'd0, 16'd100,    16'd0,  16'd0,      16'd7,      16'd100};
    rv[1]  = '{2'd1, 16'd10,     16'd8,  16'd0,      16'd1,      16'd9};
    rv[2]  = '{2'd1, 16'd9,      16'd8,  16'd0,      16'd1,      16'd8};
    rv[3]  = '{2'd1, 16'd8,      16'd8,  16'd0,      16'd1,      16'd8};
    rv[4]  = '{2'd1, 16'd3,      16'd0,  16'd0,      16'd5,      16'd0};
    rv[5]  = '{2'd1, 16'd3,      16'd2,  16'd0,      16'd5,      16'd2};
    rv[6]  = '{2'd2, 16'hFFF0,   16'd0,  16'hFFFF,   16'h0020,   16'hFFFF};
    rv[7]  = '{2'd2, 16'd100,    16'd0,  16'd200,    16'd50,     16'd150};
    rv[8]  = '{2'd2, 16'd190,    16'd0,  16'd200,    16'd50,     16'd200};
    rv[9]  = '{2'd3, 16'd55,     16'd1,  16'd99,     16'd4,      16'd55};
    rv[10] = '{2'd1, 16'hFFFF,   16'd0,  16'd0,      16'hFFFF,   16'd0};
    rv[11] = '{2'd2, 16'hFFFF,   16'd0,  16'hFFFF,   16'd1,      16'hFFFF};
    rv[12] = '{2'd2, 16'h8000,   16'd0,  16'hFFFF,   16'h8000,   16'hFFFF};
    rv[13] = '{2'd1, 16'd20,     16'd15, 16'd0,      16'd5,      16'd15};
    for (int i = 0; i < 14; i++) begin
      rt_mode = rv[i].mode; rt_cur = rv[i].cur; rt_min = rv[i].pmin;
      rt_max = rv[i].pmax; rt_step = rv[i].step;
      #1;
      check($sformatf("ramp_vec%0d", i), rt_out, rv[i].exp);
    end

    // Reset held with en high: everything stays cleared.
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst = 1'b0; en = 1'b0;
    @(posedge clk); #2;

    // Constant period 3 with a cam window on teeth 4..53.
    start_run(2'd0, 16'd3, 16'd0, 16'd0, 16'd5, 6'd4, 6'd54);
    check("const_start_tooth", tooth_idx, 0);
    check("const_start_period", cur_period, 3);
    check("const_start_phase", cam_phase, 0);
    check("const_start_vr", vr_out, 0);
    for (int r = 0; r < 3; r++) begin
      for (int t = 0; t < 58; t++) begin
        int rel;
        rel = r * REV4 + ((t < 57) ? 256 * t + 128 : 57 * 256 + 384);
        if (rel < 33410) rise_q.push_back(rel);
      end
    end
    rev_q.push_back(REV4);
    rev_q.push_back(2 * REV4);
    mon_on = 1'b1; mon_geom = 1'b1;
    // Mid-revolution input changes must not reach the running configuration.
    wait_until(1000);
    mode = 2'd1; period_min = 16'd0; ramp_step = 16'd1; period_init = 16'd7;
    wait_until(15000);
    mode = 2'd0;
    wait_until(33410);
    mon_on = 1'b0; mon_geom = 1'b0;
    check("const_period_held", cur_period, 3);
    check("const_vr_high_mid_tooth", vr_out, 1);
    check("const_tooth_before_drop", tooth_idx, 10);
    check("const_rises_left", rise_q.size(), 0);
    check("const_revs_left", rev_q.size(), 0);
    stop_run();
    check_all_zero("en_drop");

    // Accelerate 10 -> floor 8, one step per tooth.
    start_run(2'd1, 16'd10, 16'd8, 16'd0, 16'd1, 6'd4, 6'd54);
    check("reen_tooth", tooth_idx, 0);
    check("reen_period", cur_period, 10);
    check("reen_phase", cam_phase, 0);
    check("reen_cam", cam_out, 0);
    rise_q.push_back(352);
    rise_q.push_back(1024);
    rise_q.push_back(1632);
    rise_q.push_back(2208);
    mon_on = 1'b1;
    wait_until(703);  check("accel_p_t0_last", cur_period, 10);
    wait_until(704);  check("accel_p_t1", cur_period, 9);
                      check("accel_tooth1", tooth_idx, 1);
    wait_until(1343); check("accel_p_t1_last", cur_period, 9);
    wait_until(1344); check("accel_p_t2", cur_period, 8);
                      check("accel_tooth2", tooth_idx, 2);
    wait_until(1920); check("accel_p_floor", cur_period, 8);
                      check("accel_tooth3", tooth_idx, 3);
    wait_until(2300);
    mon_on = 1'b0;
    check("accel_rises_left", rise_q.size(), 0);
    stop_run();

    // Decelerate 1 -> ceiling 3 with an oversized step.
    start_run(2'd2, 16'd1, 16'd0, 16'd3, 16'd5, 6'd4, 6'd54);
    check("decel_p_start", cur_period, 1);
    wait_until(127); check("decel_p_t0_last", cur_period, 1);
    wait_until(128); check("decel_p_sat", cur_period, 3);
                     check("decel_tooth1", tooth_idx, 1);
    wait_until(384); check("decel_p_hold", cur_period, 3);
                     check("decel_tooth2", tooth_idx, 2);
    stop_run();

    // Reset during the long tooth with en held high.
    start_run(2'd0, 16'd1, 16'd0, 16'd0, 16'd0, 6'd0, 6'd0);
    for (int t = 0; t < 57; t++) rise_q.push_back(128 * t + 64);
    rise_q.push_back(57 * 128 + 192);
    mon_on = 1'b1;
    wait_until(57 * 128 + 200);
    mon_on = 1'b0;
    check("long_tooth_idx", tooth_idx, 57);
    check("long_tooth_vr", vr_out, 1);
    check("long_rises_left", rise_q.size(), 0);
    rst = 1'b1;
    @(posedge clk); #2;
    check_all_zero("rst_mid");
    @(posedge clk); #2;
    check("rst_hold_tooth", tooth_idx, 0);
    check("rst_hold_period", cur_period, 0);
    rst = 1'b0;
    @(posedge clk); #2;
    c0 = cyc;
    check("rst_resume_tooth", tooth_idx, 0);
    check("rst_resume_period", cur_period, 1);
    check("rst_resume_phase", cam_phase, 0);
    check("rst_resume_vr", vr_out, 0);
    rise_q.push_back(64);
    rise_q.push_back(192);
    mon_on = 1'b1;
    wait_until(200);
    mon_on = 1'b0;
    check("rst_resume_tooth1", tooth_idx, 1);
    check("rst_resume_rises_left", rise_q.size(), 0);
    stop_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
